// File: rtl/mzf_ram_loader_if.sv
// Byte-stream input and RAM write port of the MZF loader, bundled for the bus mux.
interface mzf_ram_loader_if;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [14:0] ram_addr;
   logic [7:0]  ram_din;
   logic        ram_en;
   logic        ram_we;

   modport master (
      output in_data, in_valid,
      input  in_ready, ram_addr, ram_din, ram_en, ram_we
   );

   modport slave (
      input  in_data, in_valid,
      output in_ready, ram_addr, ram_din, ram_en, ram_we
   );
endinterface

// File: rtl/mzf_ram_loader.sv
// Parses an MZF tape image from a byte stream and writes its body into the 32 KB RAM.
//
// state       | meaning
// ------------+---------------------------------------------------------
// S_IDLE      | waiting for start, RAM port released
// S_HEADER    | accepting the 128 header bytes, latching attr/size/addrs
// S_CHECK     | one cycle validating attribute and address range
// S_BODY_WAIT | waiting for the next body byte
// S_W_SETUP   | address/data set up, strobe low
// S_W_STROBE  | en/we high for one cycle
// S_W_HOLD    | strobe low, address/data held, pointer advances
// S_DONE      | image loaded, header fields valid
// S_ERROR     | image rejected before any write, err_code valid
module mzf_ram_loader #(
   parameter logic [15:0] RAM_BASE  = 16'h0000,
   parameter int          RAM_DEPTH = 32768,
   parameter int          HDR_LEN   = 128
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   mzf_ram_loader_if.slave       bus,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [1:0]            err_code,
   output logic [15:0]           file_size,
   output logic [15:0]           load_addr,
   output logic [15:0]           exec_addr
);

   typedef enum logic [3:0] {
      S_IDLE, S_HEADER, S_CHECK, S_BODY_WAIT, S_W_SETUP,
      S_W_STROBE, S_W_HOLD, S_DONE, S_ERROR
   } state_t;

   localparam logic [7:0]  HC_LAST = 8'(HDR_LEN - 1);
   localparam logic [16:0] DEPTH17 = 17'(RAM_DEPTH);

   state_t      state, state_nxt;
   logic [7:0]  hc;
   logic [7:0]  attr;
   logic [15:0] remaining;
   logic [14:0] wptr;
   logic [14:0] addr_q;
   logic [7:0]  din_q;
   logic        rdy;
   logic        accept;
   logic [15:0] off;
   logic [16:0] span;
   logic [1:0]  chk_code;

   assign rdy    = (state == S_HEADER) || (state == S_BODY_WAIT);
   assign accept = bus.in_valid & rdy;
   assign off    = load_addr - RAM_BASE;
   assign span   = {1'b0, off} + {1'b0, file_size};

   // Priority order matters: a bad attribute wins over any address problem.
   assign chk_code = (attr != 8'h01)        ? 2'd1 :
                     (load_addr < RAM_BASE) ? 2'd2 :
                     (span > DEPTH17)       ? 2'd3 : 2'd0;

   assign bus.in_ready = rdy;
   assign bus.ram_addr = addr_q;
   assign bus.ram_din  = din_q;

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      busy       = 1'b1;
      done       = 1'b0;
      error      = 1'b0;
      bus.ram_en = 1'b0;
      bus.ram_we = 1'b0;
      case (state)
         S_IDLE, S_DONE, S_ERROR: begin
            busy  = 1'b0;
            done  = (state == S_DONE);
            error = (state == S_ERROR);
            if (start) state_nxt = S_HEADER;
         end
         S_HEADER:
            if (accept && hc == HC_LAST) state_nxt = S_CHECK;
         S_CHECK: begin
            if (chk_code != 2'd0)        state_nxt = S_ERROR;
            else if (file_size == 16'd0) state_nxt = S_DONE;
            else                         state_nxt = S_BODY_WAIT;
         end
         S_BODY_WAIT:
            if (accept) state_nxt = S_W_SETUP;
         S_W_SETUP:
            state_nxt = S_W_STROBE;
         S_W_STROBE: begin
            bus.ram_en = 1'b1;
            bus.ram_we = 1'b1;
            state_nxt  = S_W_HOLD;
         end
         S_W_HOLD:
            state_nxt = (remaining == 16'd1) ? S_DONE : S_BODY_WAIT;
         default: begin
            busy      = 1'b0;
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hc        <= '0;
         attr      <= '0;
         remaining <= '0;
         wptr      <= '0;
         addr_q    <= '0;
         din_q     <= '0;
         err_code  <= '0;
         file_size <= '0;
         load_addr <= '0;
         exec_addr <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start) begin
                  hc        <= '0;
                  attr      <= '0;
                  err_code  <= '0;
                  file_size <= '0;
                  load_addr <= '0;
                  exec_addr <= '0;
               end
            end
            S_HEADER: begin
               if (accept) begin
                  hc <= hc + 8'd1;
                  case (hc)
                     8'd0:    attr            <= bus.in_data;
                     8'd18:   file_size[7:0]  <= bus.in_data;
                     8'd19:   file_size[15:8] <= bus.in_data;
                     8'd20:   load_addr[7:0]  <= bus.in_data;
                     8'd21:   load_addr[15:8] <= bus.in_data;
                     8'd22:   exec_addr[7:0]  <= bus.in_data;
                     8'd23:   exec_addr[15:8] <= bus.in_data;
                     default: ;
                  endcase
               end
            end
            S_CHECK: begin
               err_code  <= chk_code;
               remaining <= file_size;
               wptr      <= off[14:0];
            end
            // The only place the RAM address/data move, so they are stable around the strobe.
            S_BODY_WAIT: begin
               if (accept) begin
                  addr_q <= wptr;
                  din_q  <= bus.in_data;
               end
            end
            S_W_HOLD: begin
               wptr      <= wptr + 15'd1;
               remaining <= remaining - 16'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mzf_ram_loader.sv
// Directed bench for mzf_ram_loader: one instance with RAM_BASE 0, one with RAM_BASE 0x1000.
module tb_mzf_ram_loader;

   typedef struct {
      int          sel;
      bit          rnd;
      logic [7:0]  attr;
      logic [15:0] size;
      logic [15:0] load;
      logic [15:0] exec;
      bit          exp_done;
      logic [1:0]  exp_code;
      logic [14:0] exp_wptr;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst[2];
   logic        start[2];
   logic        busy[2];
   logic        done[2];
   logic        error[2];
   logic [1:0]  err_code[2];
   logic [15:0] fsz[2];
   logic [15:0] lda[2];
   logic [15:0] exa[2];

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   logic        prev_en[2];
   logic [14:0] prev_addr[2];
   logic [7:0]  prev_din[2];
   int          nstrobe[2];
   int          last_cyc[2];
   logic [14:0] first_addr[2];
   logic [14:0] last_addr[2];
   bit          spacing_on[2];
   logic [7:0]  mem0[int];
   logic [7:0]  mem1[int];

   mzf_ram_loader_if bus0 ();
   mzf_ram_loader_if bus1 ();

   mzf_ram_loader #(.RAM_BASE(16'h0000), .RAM_DEPTH(32768), .HDR_LEN(128)) u_dut0 (
      .clk(clk), .reset(rst[0]), .start(start[0]), .bus(bus0.slave),
      .busy(busy[0]), .done(done[0]), .error(error[0]), .err_code(err_code[0]),
      .file_size(fsz[0]), .load_addr(lda[0]), .exec_addr(exa[0])
   );

   mzf_ram_loader #(.RAM_BASE(16'h1000), .RAM_DEPTH(32768), .HDR_LEN(128)) u_dut1 (
      .clk(clk), .reset(rst[1]), .start(start[1]), .bus(bus1.slave),
      .busy(busy[1]), .done(done[1]), .error(error[1]), .err_code(err_code[1]),
      .file_size(fsz[1]), .load_addr(lda[1]), .exec_addr(exa[1])
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic fail_to(input string name);
      n_checks++;
      $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
   endtask

   function automatic logic rdy(input int s);
      return (s == 0) ? bus0.in_ready : bus1.in_ready;
   endfunction

   function automatic logic [7:0] getmem(input int s, input int a);
      if (s == 0) return mem0.exists(a) ? mem0[a] : 8'hxx;
      return mem1.exists(a) ? mem1[a] : 8'hxx;
   endfunction

   function automatic logic [7:0] body(input int i);
      return 8'hAA + 8'(i) * 8'h11;
   endfunction

   function automatic logic [7:0] hdr_byte(input int i, input vec_t v);
      case (i)
         0:       return v.attr;
         18:      return v.size[7:0];
         19:      return v.size[15:8];
         20:      return v.load[7:0];
         21:      return v.load[15:8];
         22:      return v.exec[7:0];
         23:      return v.exec[15:8];
         default: return 8'(i) ^ 8'h5A;
      endcase
   endfunction

   task automatic drv(input int s, input logic v, input logic [7:0] d);
      if (s == 0) begin bus0.in_valid = v; bus0.in_data = d; end
      else        begin bus1.in_valid = v; bus1.in_data = d; end
   endtask

   // Returns just after the edge on which the byte was accepted.
   task automatic send_byte(input int s, input logic [7:0] b, input bit rnd);
      int n;
      int k;
      @(negedge clk);
      if (rnd) begin
         k = $urandom_range(0, 2);
         repeat (k) begin
            drv(s, 1'b0, 8'($urandom));
            @(negedge clk);
         end
      end
      drv(s, 1'b1, b);
      n = 0;
      while (!rdy(s) && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) fail_to("in_ready");
      @(posedge clk);
   endtask

   task automatic mon(input int s, input logic en, input logic we,
                      input logic [14:0] a, input logic [7:0] d, input logic b);
      if (en || we) begin
         chk("strobe_we_eq_en", {31'd0, we}, {31'd0, en});
         chk("strobe_one_cycle", {31'd0, prev_en[s]}, 32'd0);
         chk("addr_stable_setup", {17'd0, a}, {17'd0, prev_addr[s]});
         chk("din_stable_setup", {24'd0, d}, {24'd0, prev_din[s]});
         chk("strobe_while_busy", {31'd0, b}, 32'd1);
         if (spacing_on[s] && nstrobe[s] > 0) chk("strobe_gap", cyc - last_cyc[s], 32'd4);
         if (s == 0) mem0[int'(a)] = d;
         else        mem1[int'(a)] = d;
         if (nstrobe[s] == 0) first_addr[s] = a;
         last_addr[s] = a;
         last_cyc[s]  = cyc;
         nstrobe[s]++;
      end else if (prev_en[s]) begin
         chk("addr_stable_hold", {17'd0, a}, {17'd0, prev_addr[s]});
         chk("din_stable_hold", {24'd0, d}, {24'd0, prev_din[s]});
      end
      prev_en[s]   = en;
      prev_addr[s] = a;
      prev_din[s]  = d;
   endtask

   always @(negedge clk) begin
      cyc++;
      mon(0, bus0.ram_en, bus0.ram_we, bus0.ram_addr, bus0.ram_din, busy[0]);
      mon(1, bus1.ram_en, bus1.ram_we, bus1.ram_addr, bus1.ram_din, busy[1]);
   end

   // Called right after a posedge, when no monitor activity can race with it.
   task automatic clear_mon(input int s, input bit spacing);
      if (s == 0) mem0.delete();
      else        mem1.delete();
      nstrobe[s]    = 0;
      spacing_on[s] = spacing;
   endtask

   task automatic pulse_start(input int s, input bit spacing);
      @(negedge clk);
      start[s] = 1'b1;
      @(posedge clk);
      clear_mon(s, spacing);
      @(negedge clk);
      start[s] = 1'b0;
   endtask

   task automatic wait_end(input int s, output int n);
      n = 0;
      @(negedge clk);
      while (!(done[s] || error[s]) && n < 40) begin
         n++;
         @(negedge clk);
      end
      if (n >= 40) fail_to("done_or_error");
   endtask

   task automatic run_vec(input vec_t v);
      int s;
      int n;
      int nb;
      s  = v.sel;
      nb = v.exp_done ? int'(v.size) : 0;
      pulse_start(s, !v.rnd);
      chk("start_busy", {31'd0, busy[s]}, 32'd1);
      chk("start_clr_done", {31'd0, done[s] | error[s]}, 32'd0);
      chk("start_clr_code", {30'd0, err_code[s]}, 32'd0);
      chk("start_clr_size", {16'd0, fsz[s]}, 32'd0);
      for (int i = 0; i < 128; i++) send_byte(s, hdr_byte(i, v), v.rnd);
      for (int i = 0; i < nb; i++) send_byte(s, body(i), v.rnd);
      wait_end(s, n);
      drv(s, 1'b0, 8'h00);
      repeat (3) @(negedge clk);
      chk("finish_latency", n, (nb > 0) ? 32'd3 : 32'd1);
      chk("done", {31'd0, done[s]}, {31'd0, v.exp_done});
      chk("error", {31'd0, error[s]}, {31'd0, !v.exp_done});
      chk("err_code", {30'd0, err_code[s]}, {30'd0, v.exp_code});
      chk("file_size", {16'd0, fsz[s]}, {16'd0, v.size});
      chk("load_addr", {16'd0, lda[s]}, {16'd0, v.load});
      chk("exec_addr", {16'd0, exa[s]}, {16'd0, v.exec});
      chk("idle_busy", {31'd0, busy[s]}, 32'd0);
      chk("idle_in_ready", {31'd0, rdy(s)}, 32'd0);
      chk("strobe_count", nstrobe[s], nb);
      if (nb > 0) begin
         chk("first_addr", {17'd0, first_addr[s]}, {17'd0, v.exp_wptr});
         chk("last_addr", {17'd0, last_addr[s]}, {17'd0, v.exp_wptr + 15'(nb - 1)});
         for (int i = 0; i < nb; i++)
            chk("ram_byte", {24'd0, getmem(s, int'(v.exp_wptr) + i)}, {24'd0, body(i)});
      end
   endtask

   vec_t vecs[13];
   vec_t ve;
   int   n;

   initial begin
      vecs[0]  = '{0, 1'b0, 8'h01, 16'h0004, 16'h1200, 16'h1200, 1'b1, 2'd0, 15'h1200};
      vecs[1]  = '{0, 1'b1, 8'h01, 16'h0004, 16'h1200, 16'h1200, 1'b1, 2'd0, 15'h1200};
      vecs[2]  = '{0, 1'b0, 8'h02, 16'h0004, 16'h1200, 16'h1200, 1'b0, 2'd1, 15'h0000};
      vecs[3]  = '{0, 1'b0, 8'h01, 16'h0011, 16'h7FF0, 16'h7FF0, 1'b0, 2'd3, 15'h0000};
      vecs[4]  = '{0, 1'b0, 8'h01, 16'h0010, 16'h7FF0, 16'h7FF0, 1'b1, 2'd0, 15'h7FF0};
      vecs[5]  = '{1, 1'b0, 8'h01, 16'h0004, 16'h0800, 16'h0800, 1'b0, 2'd2, 15'h0000};
      vecs[6]  = '{1, 1'b0, 8'h01, 16'h0004, 16'h1000, 16'h1000, 1'b1, 2'd0, 15'h0000};
      vecs[7]  = '{0, 1'b0, 8'h01, 16'h0000, 16'h2000, 16'h2000, 1'b1, 2'd0, 15'h0000};
      vecs[8]  = '{1, 1'b0, 8'h01, 16'h0001, 16'h8000, 16'hBEEF, 1'b1, 2'd0, 15'h7000};
      vecs[9]  = '{0, 1'b0, 8'h01, 16'h0001, 16'h8000, 16'hBEEF, 1'b0, 2'd3, 15'h0000};
      vecs[10] = '{1, 1'b0, 8'h02, 16'h0004, 16'h0800, 16'h0800, 1'b0, 2'd1, 15'h0000};
      vecs[11] = '{0, 1'b1, 8'h01, 16'h0006, 16'h0000, 16'h0003, 1'b1, 2'd0, 15'h0000};
      vecs[12] = '{1, 1'b0, 8'h01, 16'h0001, 16'h0FFF, 16'h0FFF, 1'b0, 2'd2, 15'h0000};

      for (int s = 0; s < 2; s++) begin
         rst[s] = 1'b1; start[s] = 1'b0;
         prev_en[s] = 1'b0; prev_addr[s] = '0; prev_din[s] = '0;
         nstrobe[s] = 0; last_cyc[s] = 0; spacing_on[s] = 1'b0;
         first_addr[s] = '0; last_addr[s] = '0;
      end
      drv(0, 1'b0, 8'h00);
      drv(1, 1'b0, 8'h00);
      repeat (3) @(negedge clk);
      rst[0] = 1'b0; rst[1] = 1'b0;
      @(negedge clk);

      for (int s = 0; s < 2; s++) begin
         chk("rst_busy", {31'd0, busy[s]}, 32'd0);
         chk("rst_done_error", {30'd0, done[s], error[s]}, 32'd0);
         chk("rst_err_code", {30'd0, err_code[s]}, 32'd0);
         chk("rst_hdr_fields", {fsz[s] | lda[s], exa[s]}, 32'd0);
         chk("rst_in_ready", {31'd0, rdy(s)}, 32'd0);
      end
      chk("rst_ram_port0", {bus0.ram_en, bus0.ram_we, bus0.ram_addr, bus0.ram_din}, 32'd0);
      chk("rst_ram_port1", {bus1.ram_en, bus1.ram_we, bus1.ram_addr, bus1.ram_din}, 32'd0);

      foreach (vecs[i]) run_vec(vecs[i]);

      // Reset while the fourth of ten body bytes is in W_SETUP.
      ve = '{0, 1'b0, 8'h01, 16'h000A, 16'h0100, 16'h0100, 1'b1, 2'd0, 15'h0100};
      pulse_start(0, 1'b1);
      for (int i = 0; i < 128; i++) send_byte(0, hdr_byte(i, ve), 1'b0);
      for (int i = 0; i < 4; i++) send_byte(0, body(i), 1'b0);
      @(negedge clk);
      chk("midbody_strobes", nstrobe[0], 32'd3);
      chk("midbody_busy", {31'd0, busy[0]}, 32'd1);
      rst[0] = 1'b1;
      @(negedge clk);
      rst[0] = 1'b0;
      drv(0, 1'b0, 8'h00);
      chk("midrst_busy", {31'd0, busy[0]}, 32'd0);
      chk("midrst_ram_en_we", {30'd0, bus0.ram_en, bus0.ram_we}, 32'd0);
      chk("midrst_outputs", {done[0], error[0], err_code[0], bus0.ram_addr}, 32'd0);
      chk("midrst_fields", {fsz[0], lda[0]}, 32'd0);
      repeat (4) @(negedge clk);
      chk("midrst_truncated", nstrobe[0], 32'd3);
      run_vec(ve);

      // start pulses while busy must not restart the header count.
      ve = '{0, 1'b0, 8'h01, 16'h0002, 16'h4000, 16'h4321, 1'b1, 2'd0, 15'h4000};
      pulse_start(0, 1'b0);
      for (int i = 0; i < 50; i++) send_byte(0, hdr_byte(i, ve), 1'b0);
      @(negedge clk);
      drv(0, 1'b0, 8'h00);
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      for (int i = 50; i < 128; i++) send_byte(0, hdr_byte(i, ve), 1'b0);
      send_byte(0, body(0), 1'b0);
      @(negedge clk);
      drv(0, 1'b0, 8'h00);
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      send_byte(0, body(1), 1'b0);
      wait_end(0, n);
      drv(0, 1'b0, 8'h00);
      chk("busy_start_done", {31'd0, done[0]}, 32'd1);
      chk("busy_start_exec", {16'd0, exa[0]}, 32'h4321);
      chk("busy_start_strobes", nstrobe[0], 32'd2);
      chk("busy_start_byte0", {24'd0, getmem(0, 32'h4000)}, {24'd0, body(0)});
      chk("busy_start_byte1", {24'd0, getmem(0, 32'h4001)}, {24'd0, body(1)});

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
